// File: rtl/decoder_skid_pkg.sv
// Shared types and the decode helper for the decoder_skid block.
package decoder_skid_pkg;

  localparam int unsigned MAX_N  = 256;
  localparam int unsigned MAX_IW = 8;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  // Result layout: bit 0 is the out-of-range flag, bit i+1 is onehot[i].
  // A caller truncates with (N+1)'(...) and gets {onehot[N-1:0], err}
  // directly, which is also the skid-buffer payload layout.
  function automatic logic [MAX_N:0] onehot_decode(input logic [MAX_IW-1:0] index,
                                                  input int unsigned     n);
    logic [MAX_N:0] r;
    logic [8:0]     pos;
    r   = '0;
    pos = {1'b0, index} + 9'd1;
    if (32'(index) < n) r[pos] = 1'b1;
    else                r[0]   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Generic 2-entry valid/ready buffer, strict FIFO order.
// state | meaning
// EMPTY | no entry held, m_valid low
// ONE   | head entry valid, tail unused
// FULL  | head and tail valid, upstream stalled
// s_ready comes from its own flop so m_ready never reaches s_ready combinationally.
module skid_buffer_2
  import decoder_skid_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         s_ready_q;
  logic         push, pop;

  assign push    = s_valid && s_ready_q;
  assign m_valid = (state_q != EMPTY);
  assign pop     = m_valid && m_ready;
  assign s_ready = s_ready_q;
  assign m_data  = head_q;

  // State, storage and registered ready; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= (state_d != FULL);
    end
  end

  // Occupancy transitions and entry moves; head is always the oldest entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = s_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          state_d = FULL;
          tail_d  = s_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/decoder_skid.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer,
// with a saturating counter of accepted out-of-range indices.
module decoder_skid
  import decoder_skid_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [$clog2(N)-1:0]       s_index,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N-1:0]               m_onehot,
  output logic                       m_err,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  input  logic                       clr_err
);

  localparam int unsigned IW = $clog2(N);

  logic [N:0]           dec_beat;
  logic [N:0]           buf_beat;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 s_hs;

  // Payload is {onehot, err}; out-of-range beats travel with onehot = 0.
  assign dec_beat = (N+1)'(onehot_decode(MAX_IW'(s_index), N));
  assign s_hs     = s_valid && s_ready;

  skid_buffer_2 #(
    .W (N + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (dec_beat),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (buf_beat)
  );

  assign m_onehot = buf_beat[N:1];
  assign m_err    = buf_beat[0];
  assign err_cnt  = err_cnt_q;

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  // Clear wins over an increment in the same cycle; increments stop at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (s_hs && dec_beat[0] && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_skid.sv
// Self-checking bench for decoder_skid: an N=8 instance and an N=6 instance
// with a 2-bit error counter, sharing clock and reset.
module tb_decoder_skid;

  localparam int N8  = 8;
  localparam int N6  = 6;
  localparam int EW8 = 8;
  localparam int EW6 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           s_valid8, s_ready8, m_valid8, m_ready8, m_err8, clr8;
  logic [2:0]     s_index8;
  logic [N8-1:0]  m_onehot8;
  logic [EW8-1:0] err_cnt8;

  logic           s_valid6, s_ready6, m_valid6, m_ready6, m_err6, clr6;
  logic [2:0]     s_index6;
  logic [N6-1:0]  m_onehot6;
  logic [EW6-1:0] err_cnt6;

  decoder_skid #(.N(N8), .ERR_CNT_W(EW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid8), .s_ready(s_ready8),
    .s_index(s_index8), .m_valid(m_valid8), .m_ready(m_ready8),
    .m_onehot(m_onehot8), .m_err(m_err8), .err_cnt(err_cnt8), .clr_err(clr8));

  decoder_skid #(.N(N6), .ERR_CNT_W(EW6)) dut6 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid6), .s_ready(s_ready6),
    .s_index(s_index6), .m_valid(m_valid6), .m_ready(m_ready6),
    .m_onehot(m_onehot6), .m_err(m_err6), .err_cnt(err_cnt6), .clr_err(clr6));

  int n_checks = 0;
  int n_errors = 0;
  int in8 = 0, out8 = 0, in6 = 0, out6 = 0;
  logic [8:0] q8[$];
  logic [8:0] q6[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference beat {err, onehot} zero-extended to 9 bits.
  function automatic logic [8:0] exp_beat(input int idx, input int n);
    logic [8:0] b;
    if (idx < n) b = 9'(1) << idx;
    else         b = 9'h100;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop/compare on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid8 && m_ready8) begin
        out8++;
        if (q8.size() == 0) chk("sb8_spurious", 64'(1), 64'(0));
        else chk("sb8_beat", 64'({m_err8, m_onehot8}), 64'(q8.pop_front()));
      end
      if (s_valid8 && s_ready8) begin
        in8++;
        q8.push_back(exp_beat(int'(s_index8), N8));
      end
      if (m_valid6 && m_ready6) begin
        out6++;
        if (q6.size() == 0) chk("sb6_spurious", 64'(1), 64'(0));
        else chk("sb6_beat", 64'({m_err6, 2'b00, m_onehot6}), 64'(q6.pop_front()));
      end
      if (s_valid6 && s_ready6) begin
        in6++;
        q6.push_back(exp_beat(int'(s_index6), N6));
      end
    end
  end

  // Reset discards everything in flight.
  always @(negedge rst_n) begin
    q8.delete();
    q6.delete();
    in8 = 0; out8 = 0; in6 = 0; out6 = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_valid8 = 1'b1; s_index8 = 3'd3; m_ready8 = 1'b0; clr8 = 1'b0;
    s_valid6 = 1'b0; s_index6 = 3'd0; m_ready6 = 1'b1; clr6 = 1'b0;
    rst_n = 1'b0;

    // Reset with a pending index
    repeat (3) tick();
    chk("rst_m_valid", 64'(m_valid8), 64'(0));
    chk("rst_onehot", 64'(m_onehot8), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt8), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rel_s_ready", 64'(s_ready8), 64'(1));
    chk("rel_m_valid", 64'(m_valid8), 64'(0));
    tick();
    chk("first_m_valid", 64'(m_valid8), 64'(1));
    chk("first_onehot", 64'(m_onehot8), 64'(8'h08));
    s_valid8 = 1'b0; m_ready8 = 1'b1;
    tick();
    chk("first_drain", 64'(m_valid8), 64'(0));

    // Streaming 0..7 at full rate
    for (int i = 0; i < 8; i++) begin
      s_valid8 = 1'b1; s_index8 = 3'(i);
      tick();
      chk("stream_onehot", 64'(m_onehot8), 64'(8'(1) << i));
      chk("stream_s_ready", 64'(s_ready8), 64'(1));
    end
    s_valid8 = 1'b0;
    tick();
    chk("stream_drain", 64'(m_valid8), 64'(0));

    // Backpressure: 5 and 2 buffered, 6 held
    m_ready8 = 1'b0;
    s_valid8 = 1'b1; s_index8 = 3'd5;
    tick();
    chk("bp_one_ready", 64'(s_ready8), 64'(1));
    s_index8 = 3'd2;
    tick();
    chk("bp_full_ready", 64'(s_ready8), 64'(0));
    s_index8 = 3'd6;
    tick();
    tick();
    chk("bp_hold_ready", 64'(s_ready8), 64'(0));
    chk("bp_hold_head", 64'(m_onehot8), 64'(8'h20));
    m_ready8 = 1'b1;
    tick();
    chk("bp_out2", 64'(m_onehot8), 64'(8'h04));
    tick();
    chk("bp_out3", 64'(m_onehot8), 64'(8'h40));
    s_valid8 = 1'b0;
    tick();
    chk("bp_drain", 64'(m_valid8), 64'(0));

    // Out-of-range on N=6
    s_valid6 = 1'b1; s_index6 = 3'd7;
    tick();
    chk("oor7_onehot", 64'(m_onehot6), 64'(0));
    chk("oor7_err", 64'(m_err6), 64'(1));
    s_index6 = 3'd4;
    tick();
    chk("in4_onehot", 64'(m_onehot6), 64'(6'h10));
    chk("in4_err", 64'(m_err6), 64'(0));
    s_index6 = 3'd6;
    tick();
    chk("oor6_onehot", 64'(m_onehot6), 64'(0));
    chk("oor6_err", 64'(m_err6), 64'(1));
    s_valid6 = 1'b0;
    tick();
    chk("oor_err_cnt", 64'(err_cnt6), 64'(2));
    chk("oor_drain", 64'(m_valid6), 64'(0));

    // Saturation at 3, then clear beating a simultaneous increment
    s_valid6 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_index6 = (k % 2 == 1) ? 3'd7 : 3'd6;
      tick();
    end
    chk("sat_err_cnt", 64'(err_cnt6), 64'(3));
    s_index6 = 3'd7; clr6 = 1'b1;
    tick();
    chk("clr_prio", 64'(err_cnt6), 64'(0));
    clr6 = 1'b0; s_index6 = 3'd6;
    tick();
    s_valid6 = 1'b0;
    chk("post_clr_inc", 64'(err_cnt6), 64'(1));
    tick();

    // Mid-stream reset with the buffer full
    m_ready8 = 1'b0;
    s_valid8 = 1'b1; s_index8 = 3'd1;
    tick();
    s_index8 = 3'd3;
    tick();
    s_valid8 = 1'b0;
    chk("mid_full_ready", 64'(s_ready8), 64'(0));
    chk("mid_full_head", 64'(m_onehot8), 64'(8'h02));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid8), 64'(0));
    chk("mid_rst_onehot", 64'(m_onehot8), 64'(0));
    chk("mid_rst_err6", 64'(err_cnt6), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(s_ready8), 64'(1));
    chk("mid_rel_m_valid", 64'(m_valid8), 64'(0));
    s_valid8 = 1'b1; s_index8 = 3'd4;
    tick();
    s_valid8 = 1'b0;
    chk("mid_new_valid", 64'(m_valid8), 64'(1));
    chk("mid_new_onehot", 64'(m_onehot8), 64'(8'h10));
    m_ready8 = 1'b1;
    tick();
    chk("mid_drain", 64'(m_valid8), 64'(0));

    // Nothing left in flight, beats in equals beats out
    repeat (2) tick();
    chk("end_q8_empty", 64'(q8.size()), 64'(0));
    chk("end_q6_empty", 64'(q6.size()), 64'(0));
    chk("end_beats8", 64'(out8), 64'(in8));
    chk("end_beats6", 64'(out6), 64'(in6));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_skid.md
Name: decoder_skid

Overview:
Registered, flow-controlled binary-to-one-hot decoder. It accepts a binary index on a valid/ready input channel and delivers the matching one-hot vector on a valid/ready output channel, through a 2-entry skid buffer. Full throughput, and no combinational path from m_ready to s_ready. Typical uses: driving arbiter grant vectors, chip selects or mux selects from binary IDs across a pipeline boundary. Out-of-range indices are flagged and counted.

Parameters:
N, 8, number of one-hot output bits (2..256); index width IW = $clog2(N) is a derived localparam, not overridable
ERR_CNT_W, 8, width of the saturating out-of-range counter

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input index valid
s_ready  output  1  decoder can accept an index
s_index  input  IW  binary index to decode
m_valid  output  1  one-hot output valid
m_ready  input  1  downstream accepts output
m_onehot  output  N  decoded one-hot vector
m_err  output  1  current output beat came from an out-of-range index
err_cnt  output  ERR_CNT_W  saturating count of accepted out-of-range indices
clr_err  input  1  synchronous clear of err_cnt

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous assert, active-low. Every register is cleared on rst_n=0.
- Reset values: s_ready=1 from the first edge after reset deasserts; m_valid=0, m_onehot=0, m_err=0, err_cnt=0.
- Transfer rules:
  - Input handshake occurs when s_valid && s_ready on a rising clk.
  - Output handshake occurs when m_valid && m_ready.
  - Once m_valid is high, m_onehot and m_err are held stable until the output handshake.
- Decode, performed before the buffer write:
  - If s_index < N: onehot = 1 << s_index, err = 0.
  - If s_index >= N (possible only when N is not a power of 2): onehot = all zeros, err = 1.
- Latency: an index accepted in cycle t appears on m_onehot in cycle t+1, provided the buffer was empty or draining.
- Buffer: 2 entries, strict FIFO order. Occupancy states are EMPTY, ONE and FULL.
  - EMPTY: push -> ONE. m_valid=0.
  - ONE: push without pop -> FULL. Pop without push -> EMPTY. Push and pop in the same cycle -> ONE; the new entry becomes head on the next cycle.
  - FULL: pop -> ONE. No push is possible because s_ready=0.
  - s_ready = (state != FULL), taken from a register only. m_valid = (state != EMPTY).
- err_cnt:
  - Increments on each input handshake whose decode err=1.
  - Saturates at 2^ERR_CNT_W - 1.
  - clr_err has priority over an increment in the same cycle, so the result is 0.
- Reset mid-operation: buffered entries are discarded, no partial beat is emitted, and err_cnt is cleared.
- s_valid is allowed to drop without a handshake; the block does not check upstream protocol violations.
- Out-of-range beats are forwarded, not dropped, so the beat count on the output always equals the beat count on the input.

Decomposition:
- Shared package decoder_skid_pkg:
  - typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t
  - function onehot_decode(index, n) returning the one-hot vector and error bit
- One natural sub-module: skid_buffer_2. It is a generic 2-entry valid/ready buffer parameterised by data width N+1 (onehot plus err).
- The top level holds the decode, the err_cnt logic and the instance of skid_buffer_2.

Test Plan:
- Reset, N=8: rst_n=0 asserted while clk runs, with s_valid=1 and s_index=3 -> m_valid=0, m_onehot=0, err_cnt=0. After deassert: s_ready=1; one cycle after accept, m_onehot=8'h08 with m_valid=1.
- Streaming, N=8: m_ready=1, indices 0..7 back to back -> one beat per cycle, m_onehot = 01, 02, 04 ... 80, each one cycle after its accept; s_ready stays 1 throughout.
- Backpressure, N=8: m_ready=0, send indices 5, 2, 6 -> 5 and 2 accepted, s_ready=0 after the second accept, and 6 is held. Then m_ready=1 -> outputs 20, 04, 40 in order, with no loss or duplication.
- Out-of-range, N=6 (IW=3): send 7, 4, 6 with m_ready=1:
  - index 7 -> m_onehot=6'h00, m_err=1
  - index 4 -> m_onehot=6'h10, m_err=0
  - index 6 -> m_onehot=6'h00, m_err=1
  - err_cnt ends at 2
- Saturation and clear, ERR_CNT_W=2, N=6: send 5 out-of-range indices -> err_cnt holds at 3. Pulse clr_err in the same cycle as an out-of-range accept -> err_cnt=0.
- Mid-stream reset: buffer FULL (indices 1 and 3 held, m_ready=0), assert rst_n=0 asynchronously between clk edges -> m_valid falls immediately. After release, the first beat out is from the next new accept, never 1 or 3.
